// File: rtl/modn_pkg.sv
// Shared types and helpers for the modulo-N counter family.
// Terminal-value decode is kept here so counter banks share one definition.
package modn_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Terminal value for a given direction: top of range counting up, zero counting down.
  function automatic int unsigned term_val(input logic up, input int unsigned modulus);
    return (up == DIR_UP) ? (modulus - 1) : 0;
  endfunction

endpackage

// File: rtl/modn_next.sv
// Combinational next-count and terminal detect for one modulo-N channel.
// Stateless so a multi-channel bank can share or replicate it freely.
module modn_next
  import modn_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 47
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             at_term
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(term_val(DIR_UP, MODULUS));

  logic [WIDTH-1:0] term;

  always_comb begin
    term    = WIDTH'(term_val(up, MODULUS));
    at_term = (count == term);
  end

  generate
    if (MODULUS == (1 << WIDTH)) begin : g_pow2
      // Full binary range: plain overflow/underflow is already the modular wrap.
      always_comb begin
        next_count = (up == DIR_UP) ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end else begin : g_mod
      always_comb begin
        next_count = '0;
        if (at_term)
          next_count = (up == DIR_UP) ? '0 : MAXV;
        else if (up == DIR_UP)
          next_count = count + WIDTH'(1);
        else
          next_count = count - WIDTH'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/modn_counter.sv
// Modulo-N up/down counter with parallel load, one-shot halt and wrap/done/load_err flags.
// state | meaning
// RUN   | counting (or idle with en=0); wraps or halts at the terminal value
// HALT  | one-shot finished; count frozen until load or reset
module modn_counter
  import modn_pkg::*;
#(
  parameter int unsigned WIDTH   = 6,
  parameter int unsigned MODULUS = 47
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             load_err
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state;
  logic [WIDTH-1:0] next_count;
  logic             at_term;
  logic             din_ok;

  modn_next #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .count     (count),
    .up        (up),
    .next_count(next_count),
    .at_term   (at_term)
  );

  assign tc     = at_term;
  assign din_ok = ({1'b0, din} < MOD_EXT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
      state    <= RUN;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        // Out-of-range loads saturate to the top state rather than leaving the range.
        count    <= din_ok ? din : MAXV;
        load_err <= ~din_ok;
        done     <= 1'b0;
        state    <= RUN;
      end else if (en && state == RUN) begin
        if (at_term && one_shot) begin
          done  <= 1'b1;
          state <= HALT;
        end else begin
          count <= next_count;
          wrap  <= at_term;
        end
      end
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// Self-checking bench for modn_counter (WIDTH=6, MODULUS=47): directed plan plus random run.
// Reference model uses modular arithmetic on integers.
module tb_modn_counter;

  localparam int W = 6;
  localparam int M = 47;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] din;
  logic         up;
  logic         one_shot;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         done;
  logic         load_err;

  int total = 0;
  int bad   = 0;

  int mc;
  bit mhalt, mdone, mwrap, merr;

  always #5 clk = ~clk;

  modn_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .din     (din),
    .up      (up),
    .one_shot(one_shot),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap),
    .done    (done),
    .load_err(load_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mc = 0; mhalt = 0; mdone = 0; mwrap = 0; merr = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held at that edge.
  task automatic model_edge();
    int nxt;
    mwrap = 0;
    merr  = 0;
    if (load) begin
      if (int'(din) < M) mc = int'(din);
      else begin mc = M - 1; merr = 1; end
      mdone = 0;
      mhalt = 0;
    end else if (en && !mhalt) begin
      if (one_shot && mc == (up ? M - 1 : 0)) begin
        mhalt = 1;
        mdone = 1;
      end else begin
        nxt   = (mc + (up ? 1 : M - 1)) % M;
        mwrap = up ? (nxt < mc) : (nxt > mc);
        mc    = nxt;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, int'(count), mc);
    chk({tag, ".tc"}, int'(tc), int'(mc == (up ? M - 1 : 0)));
    chk({tag, ".wrap"}, int'(wrap), int'(mwrap));
    chk({tag, ".done"}, int'(done), int'(mdone));
    chk({tag, ".load_err"}, int'(load_err), int'(merr));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0; din = '0; up = 1'b1; one_shot = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b1;
    step("release");
    chk("reset.tc_up", int'(tc), 0);
    up = 1'b0;
    #1;
    chk("reset.tc_dn", int'(tc), 1);
    up = 1'b1;

    // Free-run up through the full range and wrap.
    en = 1'b1;
    for (int i = 0; i < M - 1; i++) step("up_run");
    chk("up.top_count", int'(count), 46);
    chk("up.top_tc", int'(tc), 1);
    step("up_wrap");
    chk("up.wrap_count", int'(count), 0);
    chk("up.wrap_pulse", int'(wrap), 1);
    step("up_after_wrap");
    chk("up.wrap_one_cycle", int'(wrap), 0);

    // Loads, in range and out of range.
    en = 1'b0; load = 1'b1; din = 6'd4;
    step("load4");
    chk("load4.count", int'(count), 4);
    chk("load4.err", int'(load_err), 0);
    din = 6'd50; en = 1'b1;
    step("load50");
    chk("load50.count", int'(count), 46);
    chk("load50.err", int'(load_err), 1);
    load = 1'b0; en = 1'b0;
    step("load_idle");

    // Count down from 0 with wrap.
    load = 1'b1; din = 6'd0;
    step("load0");
    load = 1'b0; up = 1'b0; en = 1'b1;
    step("dn_wrap");
    chk("dn.wrap_count", int'(count), 46);
    chk("dn.wrap_pulse", int'(wrap), 1);
    step("dn_45");
    step("dn_44");
    chk("dn.count44", int'(count), 44);

    // Direction flip while sitting at the up-terminal.
    en = 1'b0; up = 1'b1; load = 1'b1; din = 6'd46;
    step("flip_load");
    load = 1'b0; up = 1'b0;
    #1;
    chk("flip.tc", int'(tc), 0);
    en = 1'b1;
    step("flip_step");
    chk("flip.count", int'(count), 45);

    // One-shot up to the terminal, then halt.
    one_shot = 1'b1; up = 1'b1; en = 1'b0; load = 1'b1; din = 6'd44;
    step("os_load");
    load = 1'b0; en = 1'b1;
    step("os_45");
    step("os_46");
    step("os_halt");
    chk("os.halt_count", int'(count), 46);
    chk("os.done", int'(done), 1);
    up = 1'b0;
    step("os_frozen_dn");
    one_shot = 1'b0;
    step("os_frozen_free");
    chk("os.frozen", int'(count), 46);
    load = 1'b1; din = 6'd4;
    step("os_reload");
    chk("os.reload_count", int'(count), 4);
    chk("os.reload_done", int'(done), 0);

    // One-shot that starts on its terminal halts immediately.
    load = 1'b1; din = 6'd0; up = 1'b0; one_shot = 1'b1;
    step("os0_load");
    load = 1'b0;
    step("os0_halt");
    chk("os0.done", int'(done), 1);

    // Asynchronous reset mid-count.
    load = 1'b1; din = 6'd19; up = 1'b1; one_shot = 1'b0;
    step("ar_load");
    load = 1'b0;
    step("ar_20");
    chk("ar.count20", int'(count), 20);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;
    step("ar_resume");
    chk("ar.resume", int'(count), 1);

    // Asynchronous reset while halted.
    one_shot = 1'b1; load = 1'b1; din = 6'd46;
    step("ah_load");
    load = 1'b0;
    step("ah_halt");
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("async_rst_halt");
    @(negedge clk);
    rst = 1'b1;
    one_shot = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 15) == 0);
      din  = W'($urandom_range(0, 63));
      en   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) up = ~up;
      if ($urandom_range(0, 19) == 0) one_shot = ~one_shot;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modn_counter.md
Name: modn_counter

Overview:
- Parametrised modulo-N counter with synchronous parallel load, up/down direction, count enable, and free-running or one-shot mode.
- Generalises the fixed mod-47 load counter to any modulus and width.
- Adds terminal-count, wrap and done flags for cascading and for use as a timer or divider stage in the sequential-logic library.

Parameters:
- WIDTH, 6: count register width in bits.
- MODULUS, 47: number of count states, 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH. Out-of-range values are a compile-time error via a generate-time check.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  count enable. One step per clk edge while high.
- load  input  1  synchronous parallel load strobe.
- din  input  WIDTH  load value.
- up  input  1  direction: 1 counts up, 0 counts down.
- one_shot  input  1  1 = halt at terminal value, 0 = wrap (free-run).
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count decode: count == term. term is MODULUS-1 when up=1, and 0 when up=0. Combinational from count and up.
- wrap  output  1  registered 1-cycle pulse, high in the cycle count shows the wrapped value.
- done  output  1  registered, sticky. One-shot has reached its terminal value.
- load_err  output  1  registered 1-cycle pulse, din >= MODULUS on a load.

Behaviour:
- Reset (rst=0, asynchronous): count=0, wrap=0, done=0, load_err=0, state=RUN. Held while rst=0; release is synchronous to the next clk edge.
- Priority per edge: reset > load > enable. Direction and mode are sampled every edge; a change takes effect on that edge.
- load=1:
  - count <= din if din < MODULUS.
  - Otherwise count <= MODULUS-1 and load_err=1 for one cycle.
  - done cleared, state <= RUN, wrap=0.
  - en is ignored that cycle.
- Latency: count reflects load or step one edge after the strobe.
- State machine:
  - RUN, en=1, count != term: count +1 (up) or -1 (down).
  - RUN, en=1, count == term, one_shot=0: count <= 0 (up) or MODULUS-1 (down); wrap=1 next cycle.
  - RUN, en=1, count == term, one_shot=1: count holds, done <= 1, state <= HALT. No wrap pulse.
  - HALT: count frozen regardless of en, up or one_shot. Exit only by load or reset.
  - en=0: count and state hold; wrap=0.
- Direction flip while at a terminal:
  - tc re-evaluates immediately against the new direction.
  - Example: at 46 with up switched to 0, tc=0 and the next enabled step gives 45.
- One-shot starting at terminal with en=1: halts on that edge, done=1, count unchanged.
- MODULUS == 2**WIDTH: wrap is natural binary overflow; no compare logic is needed, but the behaviour is identical.
- Arithmetic is WIDTH bits, unsigned. There is no intermediate value outside 0..MODULUS-1.
- Asynchronous reset mid-count or mid-HALT: all outputs return to reset values immediately, not on the next edge.

Decomposition:
- Shared package modn_pkg:
  - state enum {RUN, HALT}.
  - Direction constants DIR_UP=1, DIR_DN=0.
  - Function term_val(up, MODULUS).
- One natural sub-module: modn_next. Combinational next-count and wrap-detect given count, up and MODULUS. Reusable by a future multi-channel counter bank.
- The top holds the registers, the FSM and the flags.

Test Plan (WIDTH=6, MODULUS=47):
- Reset then release, en=0 -> count=0, tc=1 (up=1? no: tc=0 when up=1, tc=1 when up=0), wrap=done=load_err=0.
- up=1, one_shot=0, en=1 from 0 for 46 edges:
  - count=46, tc=1.
  - Next edge: count=0, wrap=1 for exactly one cycle.
- load=1, din=4 for one edge -> count=4 next edge, load_err=0. Then load=1, din=50 -> count=46, load_err=1 pulse.
- up=0, en=1 from 0 -> count=46, wrap pulse. Continue -> 45, 44.
- one_shot=1, up=1, load 44, en=1 -> 45, 46; next edge count holds 46, done=1. Further en has no effect. Then load 4 -> count=4, done=0.
- Counting at 20 with rst pulled low 2 ns after an edge -> count=0 and flags 0 before the next clk edge. After release, counting resumes from 0.
